pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_pkg.sv | 42 ++++
 rtl/pwm_dwell_timer.sv | 35 +++
 rtl/pwm_fade_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared definitions for the PWM fade controller.
//   DWELL_W_DEFAULT : default width of the per-level dwell count
//   pwm_state_e     : fade FSM state encoding
//   step_up/down    : saturating level arithmetic used by the fade FSM
package pwm_pkg;

  localparam int DWELL_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } pwm_state_e;

  // Next level going up: 9-bit sum so 250+30 clamps to the ceiling instead of wrapping.
  function automatic logic [7:0] step_up(input logic [7:0] level,
                                         input logic [7:0] step,
                                         input logic [7:0] ceil);
    logic [8:0] sum_s;
    sum_s = {1'b0, level} + {1'b0, step};
    if (sum_s >= {1'b0, ceil}) begin
      return ceil;
    end else begin
      return sum_s[7:0];
    end
  endfunction

  // Next level going down: 9-bit signed difference so 0-10 clamps to the floor.
  function automatic logic [7:0] step_down(input logic [7:0] level,
                                           input logic [7:0] step,
                                           input logic [7:0] floor);
    logic signed [8:0] diff_s;
    diff_s = $signed({1'b0, level}) - $signed({1'b0, step});
    if (diff_s < $signed({1'b0, floor})) begin
      return floor;
    end else begin
      return diff_s[7:0];
    end
  endfunction

endpackage

// File: rtl/pwm_dwell_timer.sv
// pwm_dwell_timer -- countdown that measures how long one duty level is held.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with load_val (dwell - 1)
//   load_val   : reload value
//   en         : counting enabled (fade running)
//   expire     : high in the last cycle of the current dwell
module pwm_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_r;

  // Counter reaches zero in the final held cycle; a load in that cycle restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en && (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl -- ramps the PWM duty between two levels, or passes the
// SPI duty register through when idle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, stop       : one-cycle pulses to begin / abort a fade (stop wins)
//   cfg_min/max/step  : level range and increment (step 0 acts as 1)
//   cfg_dwell         : cycles each level is held (0 acts as 1)
//   cfg_loop          : 0 one-shot ramp up, 1 triangle until stop
//   spi_duty          : duty used while idle
//   duty_out          : registered duty to the PWM peripheral
//   busy, done        : fade running / one-shot completion pulse
//   dir_down          : fade currently descending
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         cfg_min,
  input  logic [7:0]         cfg_max,
  input  logic [7:0]         cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic [7:0]         spi_duty,
  output logic [7:0]         duty_out,
  output logic               busy,
  output logic               done,
  output logic               dir_down
);

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  pwm_state_e         state_r;
  logic [7:0]         min_r, max_r, step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               loop_r;

  logic [7:0]         step_eff_s, first_level_s, up_level_s, down_level_s;
  logic [DWELL_W-1:0] dwell_eff_s, timer_val_s;
  logic               at_max_s, at_min_s, single_s;
  logic               timer_load_s, timer_en_s, expire_s;

  // Normalised config and next-level candidates.
  always_comb begin
    step_eff_s    = (cfg_step == 8'd0) ? 8'd1 : cfg_step;
    dwell_eff_s   = (cfg_dwell == {DWELL_W{1'b0}}) ? DWELL_ONE : cfg_dwell;
    // min >= max collapses the fade onto the single level max.
    first_level_s = (cfg_min >= cfg_max) ? cfg_max : cfg_min;
    single_s      = (min_r >= max_r);
    at_max_s      = (duty_out == max_r);
    at_min_s      = (duty_out == min_r);
    up_level_s    = step_up(duty_out, step_r, max_r);
    down_level_s  = step_down(duty_out, step_r, min_r);
  end

  // Timer reload whenever a new level starts being held.
  always_comb begin
    timer_load_s = 1'b0;
    timer_val_s  = dwell_r - DWELL_ONE;
    timer_en_s   = (state_r == ST_UP) || (state_r == ST_DOWN);
    if ((state_r == ST_IDLE) && start && !stop) begin
      timer_load_s = 1'b1;
      timer_val_s  = dwell_eff_s - DWELL_ONE;
    end else if (timer_en_s && !stop && expire_s) begin
      // The only expiry that ends the fade is the max level of a one-shot.
      timer_load_s = !((state_r == ST_UP) && at_max_s && !loop_r);
    end else begin
      timer_load_s = 1'b0;
    end
  end

  pwm_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .en       (timer_en_s),
    .expire   (expire_s)
  );

  // Fade FSM with registered outputs and latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      duty_out <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir_down <= 1'b0;
      min_r    <= 8'd0;
      max_r    <= 8'd0;
      step_r   <= 8'd0;
      dwell_r  <= {DWELL_W{1'b0}};
      loop_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done     <= 1'b0;
          dir_down <= 1'b0;
          if (start && !stop) begin
            min_r    <= cfg_min;
            max_r    <= cfg_max;
            step_r   <= step_eff_s;
            dwell_r  <= dwell_eff_s;
            loop_r   <= cfg_loop;
            duty_out <= first_level_s;
            busy     <= 1'b1;
            state_r  <= ST_UP;
          end else begin
            duty_out <= spi_duty;
            busy     <= 1'b0;
          end
        end
        ST_UP: begin
          if (stop) begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            dir_down <= 1'b0;
          end else if (expire_s) begin
            if (!at_max_s) begin
              duty_out <= up_level_s;
            end else if (!loop_r) begin
              // Idle pass-through starts with the DONE cycle.
              state_r  <= ST_DONE;
              done     <= 1'b1;
              duty_out <= spi_duty;
            end else if (single_s) begin
              duty_out <= max_r;
            end else begin
              state_r  <= ST_DOWN;
              dir_down <= 1'b1;
              duty_out <= down_level_s;
            end
          end else begin
            duty_out <= duty_out;
          end
        end
        ST_DOWN: begin
          if (stop) begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            dir_down <= 1'b0;
          end else if (expire_s) begin
            if (at_min_s) begin
              state_r  <= ST_UP;
              dir_down <= 1'b0;
              duty_out <= up_level_s;
            end else begin
              duty_out <= down_level_s;
            end
          end else begin
            duty_out <= duty_out;
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          dir_down <= 1'b0;
          duty_out <= spi_duty;
        end
        default: begin
          state_r  <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          dir_down <= 1'b0;
          duty_out <= spi_duty;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  cfg_min = 8'd0, cfg_max = 8'd0, cfg_step = 8'd0;
  logic [15:0] cfg_dwell = 16'd0;
  logic        cfg_loop = 1'b0;
  logic [7:0]  spi_duty = 8'd0;
  logic [7:0]  duty_out;
  logic        busy, done, dir_down;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] duty;
    logic       busy;
    logic       dir;
    logic       done;
  } exp_t;

  exp_t q[$];

  pwm_fade_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .spi_duty(spi_duty),
    .duty_out(duty_out), .busy(busy), .done(done), .dir_down(dir_down)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int duty, input bit b, input bit d, input bit dn);
    exp_t e;
    e.duty = 8'(duty); e.busy = b; e.dir = d; e.done = dn;
    q.push_back(e);
  endtask

  // Expected per-cycle outputs, starting with the cycle after the start edge.
  task automatic build(input int mn, input int mx, input int st, input int dw,
                       input bit lp, input int sp, input int nlev);
    int s, d, lvl, cnt;
    bit dn;
    s = (st == 0) ? 1 : st;
    d = (dw == 0) ? 1 : dw;
    q.delete();
    if (mn >= mx) begin
      cnt = lp ? nlev : 1;
      for (int i = 0; i < cnt; i++)
        for (int j = 0; j < d; j++) push(mx, 1'b1, 1'b0, 1'b0);
    end else begin
      lvl = mn; dn = 1'b0; cnt = 0;
      forever begin
        for (int j = 0; j < d; j++) push(lvl, 1'b1, dn, 1'b0);
        cnt++;
        if (!lp && lvl == mx) break;
        if (lp && cnt >= nlev) break;
        if (!dn) begin
          if (lvl == mx) begin dn = 1'b1; lvl = (lvl - s < mn) ? mn : lvl - s; end
          else lvl = (lvl + s > mx) ? mx : lvl + s;
        end else begin
          if (lvl == mn) begin dn = 1'b0; lvl = (lvl + s > mx) ? mx : lvl + s; end
          else lvl = (lvl - s < mn) ? mn : lvl - s;
        end
      end
    end
    if (!lp) begin
      push(sp, 1'b1, 1'b0, 1'b1);
      push(sp, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Start a fade, check every cycle against the model, scramble inputs that must be ignored.
  task automatic run(input string name, input int mn, input int mx, input int st,
                     input int dw, input bit lp, input int sp, input int nlev,
                     input int stop_idx);
    build(mn, mx, st, dw, lp, sp, nlev);
    cfg_min = 8'(mn); cfg_max = 8'(mx); cfg_step = 8'(st);
    cfg_dwell = 16'(dw); cfg_loop = lp; spi_duty = 8'(sp);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      chk({name, ".duty"}, 32'(duty_out), 32'(q[k].duty));
      chk({name, ".busy"}, 32'(busy), 32'(q[k].busy));
      chk({name, ".dir"}, 32'(dir_down), 32'(q[k].dir));
      chk({name, ".done"}, 32'(done), 32'(q[k].done));
      if (k == stop_idx) break;
      if (k < q.size() - 2) begin
        cfg_min = 8'($urandom); cfg_max = 8'($urandom); cfg_step = 8'($urandom);
        cfg_dwell = 16'($urandom_range(0, 5)); cfg_loop = 1'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end else begin
        start = 1'b0;
      end
      if (k < q.size() - 1) tick();
    end
    start = 1'b0;
    if (lp || stop_idx >= 0) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk({name, ".stop_busy"}, 32'(busy), 32'd0);
      chk({name, ".stop_done"}, 32'(done), 32'd0);
      chk({name, ".stop_dir"}, 32'(dir_down), 32'd0);
      tick();
      chk({name, ".stop_duty"}, 32'(duty_out), 32'(sp));
      chk({name, ".stop_done2"}, 32'(done), 32'd0);
    end
    tick();
    chk({name, ".idle_done"}, 32'(done), 32'd0);
    chk({name, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state.
    spi_duty = 8'hA5;
    #3;
    chk("rst.duty", 32'(duty_out), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.dir", 32'(dir_down), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle.follow", 32'(duty_out), 32'hA5);
    spi_duty = 8'h3C;
    tick();
    chk("idle.follow2", 32'(duty_out), 32'h3C);

    // Start and stop together: stop wins, stays idle.
    spi_duty = 8'h33; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("coinc.busy", 32'(busy), 32'd0);
    chk("coinc.duty", 32'(duty_out), 32'h33);

    run("oneshot", 10, 40, 10, 3, 1'b0, 8'h11, 0, -1);
    run("sat", 200, 250, 30, 1, 1'b0, 8'h22, 0, -1);
    run("tri", 0, 20, 10, 2, 1'b1, 8'h44, 9, -1);
    run("abort", 10, 40, 10, 3, 1'b0, 8'h66, 0, 6);
    run("zero", 5, 9, 0, 0, 1'b0, 8'h77, 0, -1);
    run("single", 50, 50, 7, 2, 1'b0, 8'h88, 0, -1);
    run("single_loop", 90, 30, 7, 2, 1'b1, 8'h99, 4, -1);

    for (int r = 0; r < 20; r++) begin
      run("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 80)),
          int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 255)),
          int'($urandom_range(4, 12)), -1);
    end

    // Reset in the middle of a triangle fade.
    cfg_min = 8'd0; cfg_max = 8'd20; cfg_step = 8'd10; cfg_dwell = 16'd2; cfg_loop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rstmid.pre_duty", 32'(duty_out), 32'd20);
    rst_n = 1'b0;
    #1;
    chk("rstmid.duty", 32'(duty_out), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.done", 32'(done), 32'd0);
    chk("rstmid.dir", 32'(dir_down), 32'd0);
    spi_duty = 8'h55;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstmid.after_duty", 32'(duty_out), 32'h55);
    chk("rstmid.after_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
